qpsk_mapper: RTL and testbench

Gray-coded QPSK symbol mapper for the transmit datapath. It converts each bit pair (bit1, bit2) into one complex constellation point. The point is output as signed fixed-point real and imaginary words of width WIDTH. The block sits between the bit source/scrambler and the pulse-shaping/IFFT stage, and registers its output with one cycle of latency.

---
 rtl/qpsk_mapper.sv | 60 ++++++
 tb/tb_qpsk_mapper.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/qpsk_mapper.sv
// Gray-coded QPSK symbol mapper: each (bit1, bit2) pair becomes one signed
// fixed-point constellation point (re, im), registered with one cycle of latency.
module qpsk_mapper #(
  parameter int              WIDTH = 32,
  parameter int              FRAC  = 30,
  parameter logic [WIDTH-1:0] AMP  = WIDTH'(759250125)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             bit1,
  input  logic             bit2,
  output logic             out_valid,
  output logic [WIDTH-1:0] re,
  output logic [WIDTH-1:0] im
);

  // Negated magnitude is a constant, so the datapath reduces to a per-axis mux.
  localparam logic [WIDTH-1:0] NEG_AMP = ~AMP + WIDTH'(1);

  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("qpsk_mapper: FRAC must lie in [0, WIDTH-1]");
  end

  if (AMP == '0 || AMP[WIDTH-1]) begin : g_bad_amp
    $error("qpsk_mapper: AMP must satisfy 0 < AMP < 2^(WIDTH-1)");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] re_q, re_d;
  logic [WIDTH-1:0] im_q, im_d;

  // Bits are only looked at on valid cycles, so idle-cycle X never reaches re/im.
  always_comb begin
    out_valid_d = in_valid;
    re_d        = re_q;
    im_d        = im_q;
    if (in_valid) begin
      re_d = bit1 ? NEG_AMP : AMP;
      im_d = bit2 ? NEG_AMP : AMP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      re_q        <= re_d;
      im_q        <= im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign re        = re_q;
  assign im        = im_q;

endmodule

// File: tb/tb_qpsk_mapper.sv
// Self-checking bench for qpsk_mapper: a scoreboard queue holds the expected
// (valid, re, im) for every driven cycle and is popped one cycle later.
module tb_qpsk_mapper;

  localparam logic [31:0] POS32 = 32'h2D413CCD;
  localparam logic [31:0] NEG32 = 32'hD2BEC333;
  localparam logic [15:0] POS16 = 16'h2D41;
  localparam logic [15:0] NEG16 = 16'hD2BF;

  typedef struct packed {
    logic        valid;
    logic [31:0] re;
    logic [31:0] im;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        bit1 = 1'b0;
  logic        bit2 = 1'b0;
  logic        out_valid;
  logic [31:0] re, im;
  logic        out_valid16;
  logic [15:0] re16, im16;

  exp_t        sb[$];
  logic [31:0] m_re = '0;
  logic [31:0] m_im = '0;
  int          tests_run = 0;
  int          tests_failed = 0;

  qpsk_mapper dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bit1(bit1), .bit2(bit2),
    .out_valid(out_valid), .re(re), .im(im)
  );

  qpsk_mapper #(.WIDTH(16), .FRAC(14), .AMP(16'd11585)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bit1(bit1), .bit2(bit2),
    .out_valid(out_valid16), .re(re16), .im(im16)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and push what the outputs must show after the next edge.
  task automatic driveSymbol(input logic v, input logic b1, input logic b2);
    exp_t e;
    in_valid = v;
    bit1     = b1;
    bit2     = b2;
    if (v) begin
      m_re = b1 ? NEG32 : POS32;
      m_im = b2 ? NEG32 : POS32;
    end
    e.valid = v;
    e.re    = m_re;
    e.im    = m_im;
    sb.push_back(e);
  endtask

  task automatic scoreboardCheck(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_valid"}, {31'd0, out_valid}, {31'd0, e.valid});
      checkOutput({tag, "_re"}, re, e.re);
      checkOutput({tag, "_im"}, im, e.im);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic b1, input logic b2);
    @(negedge clk);
    driveSymbol(v, b1, b2);
    @(posedge clk);
    #1;
    scoreboardCheck(tag);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_re"}, re, 32'd0);
    checkOutput({tag, "_im"}, im, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1;
    checkZero("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // All four constellation points back to back.
    applyStimulus("pt00", 1'b1, 1'b0, 1'b0);
    applyStimulus("pt01", 1'b1, 1'b0, 1'b1);
    applyStimulus("pt10", 1'b1, 1'b1, 1'b0);
    applyStimulus("pt11", 1'b1, 1'b1, 1'b1);

    // Narrow instance with pattern 01.
    applyStimulus("p16_01", 1'b1, 1'b0, 1'b1);
    checkOutput("p16_valid", {31'd0, out_valid16}, 32'd1);
    checkOutput("p16_re", {16'd0, re16}, {16'd0, POS16});
    checkOutput("p16_im", {16'd0, im16}, {16'd0, NEG16});

    // bit1 toggles every cycle, bit2 every other cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus("toggle", 1'b1, i[0], i[1]);
    end

    // Hold: one valid 10, then idle cycles carrying different bits.
    applyStimulus("hold_load", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("hold_idle", 1'b0, 1'b0, 1'b1);
    end
    applyStimulus("hold_x", 1'b0, 1'bx, 1'bx);

    // Alternating valid: outputs change only after valid cycles.
    for (int i = 0; i < 6; i++) begin
      applyStimulus("alt", i[0] == 1'b0, i[1], ~i[1]);
    end

    // Mid-stream reset with a symbol in flight.
    applyStimulus("pre_rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    bit1     = 1'b1;
    bit2     = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkZero("rst_async");
    @(posedge clk);
    #1;
    checkZero("rst_held");
    sb.delete();
    m_re = '0;
    m_im = '0;

    // Recovery: first edge after release samples 11.
    @(negedge clk);
    rst = 1'b0;
    driveSymbol(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    scoreboardCheck("recover11");
    applyStimulus("recover_idle", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
